kf_axi_result_burst_writer: RTL and testbench

//  Parametrised AXI4 write master that stores the Kalman filter results X_k|k and P_k|k to DDR4 after each update step.

---
 rtl/kf_axi_result_burst_writer.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_kf_axi_result_burst_writer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kf_axi_result_burst_writer.sv
// kf_axi_result_burst_writer
// AXI4 write master that copies the Kalman filter results X_k|k and P_k|k to DDR4
// after each update step. Both inputs are snapshotted on start. X is written first,
// then P, each as a series of INCR bursts. Every burst is split at MAX_BURST beats and
// at 4 KB boundaries. Only one burst is outstanding at a time. P can be written in full
// or as its upper triangle only. Write errors are collected into a sticky err flag and
// do not stop the transfer.
//
// state  | meaning
// -------+----------------------------------------------------------------
// S_IDLE | no transfer; start is accepted here
// S_AW   | address phase of the current burst, awvalid held until awready
// S_W    | data beats of the current burst, no bubbles while wready=1
// S_B    | waiting for the write response of the current burst
module kf_axi_result_burst_writer #(
  parameter int STATE_DIM = 12,
  parameter int ELEM_W    = 64,
  parameter int AXI_DW    = 512,
  parameter int AXI_AW    = 32,
  parameter int MAX_BURST = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic                                  p_sym_mode,
  input  logic [AXI_AW-1:0]                     x_base,
  input  logic [AXI_AW-1:0]                     p_base,
  input  logic [STATE_DIM*ELEM_W-1:0]           x_in,
  input  logic [STATE_DIM*STATE_DIM*ELEM_W-1:0] p_in,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  err,
  output logic [1:0]                            err_resp,
  output logic [AXI_AW-1:0]                     axi_awaddr,
  output logic [7:0]                            axi_awlen,
  output logic [2:0]                            axi_awsize,
  output logic [1:0]                            axi_awburst,
  output logic                                  axi_awvalid,
  input  logic                                  axi_awready,
  output logic [AXI_DW-1:0]                     axi_wdata,
  output logic [AXI_DW/8-1:0]                   axi_wstrb,
  output logic                                  axi_wlast,
  output logic                                  axi_wvalid,
  input  logic                                  axi_wready,
  input  logic [1:0]                            axi_bresp,
  input  logic                                  axi_bvalid,
  output logic                                  axi_bready
);

  localparam int N        = STATE_DIM;
  localparam int LANES    = AXI_DW / ELEM_W;
  localparam int BYTES    = AXI_DW / 8;
  localparam int LANE_B   = ELEM_W / 8;
  localparam int SIZE     = $clog2(BYTES);
  localparam int X_WORDS  = N;
  localparam int PF_WORDS = N * N;
  localparam int PS_WORDS = N * (N + 1) / 2;
  localparam int X_BEATS  = (X_WORDS + LANES - 1) / LANES;
  localparam int PF_BEATS = (PF_WORDS + LANES - 1) / LANES;
  localparam int PS_BEATS = (PS_WORDS + LANES - 1) / LANES;
  localparam int BW       = $clog2(PF_BEATS + 1);
  localparam int WW       = $clog2(PF_WORDS + 1);
  localparam int CW       = $clog2(N + 1);

  localparam logic REG_X = 1'b0;
  localparam logic REG_P = 1'b1;

  localparam logic [AXI_AW-1:0] ALIGN_MASK = AXI_AW'(BYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

  state_t state_q, state_d;

  // snapshot of the filter results, taken at start
  logic [N*ELEM_W-1:0]   x_q;
  logic [N*N*ELEM_W-1:0] p_q;
  logic [AXI_AW-1:0]     p_base_q;
  logic                  p_sym_q;

  // region progress: next burst address and beats still to issue in this region
  logic                  region_q;
  logic [AXI_AW-1:0]     cur_addr_q;
  logic [BW-1:0]         left_q;

  // word cursor: (row, col) for P, col alone indexes X; words still to pack
  logic [CW-1:0]         r_q, c_q;
  logic [WW-1:0]         wleft_q;

  // AXI output registers
  logic [AXI_AW-1:0]     awaddr_q;
  logic [7:0]            awlen_q;
  logic [AXI_DW-1:0]     wdata_q;
  logic [AXI_DW/8-1:0]   wstrb_q;
  logic                  wlast_q;
  logic [7:0]            beat_q;

  logic                  done_q;
  logic                  err_q;
  logic [1:0]            err_resp_q;

  // FSM strobes
  logic start_acc, aw_hs, w_hs, b_hs, fin;

  // burst planner signals
  logic [AXI_AW-1:0] plan_addr;
  logic [BW-1:0]     plan_left;
  logic [12:0]       to_4k;
  logic [8:0]        plan_n;

  // beat builder signals
  logic [AXI_DW-1:0]   beat_data;
  logic [AXI_DW/8-1:0] beat_strb;
  logic [CW-1:0]       br, bc;
  logic [WW-1:0]       bleft;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // next-state logic and handshake strobes
  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;
    b_hs      = 1'b0;
    fin       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_d   = S_AW;
        end
      end
      S_AW: begin
        if (axi_awready) begin
          aw_hs   = 1'b1;
          state_d = S_W;
        end
      end
      S_W: begin
        if (axi_wready) begin
          w_hs = 1'b1;
          if (wlast_q) state_d = S_B;
        end
      end
      S_B: begin
        if (axi_bvalid) begin
          b_hs = 1'b1;
          if (left_q == '0 && region_q == REG_P) begin
            fin     = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_AW;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // plan the next burst: start of X, start of P, or continuation of the current region
  always_comb begin
    plan_addr = cur_addr_q;
    plan_left = left_q;
    if (state_q == S_IDLE) begin
      plan_addr = x_base & ~ALIGN_MASK;
      plan_left = BW'(X_BEATS);
    end else if (left_q == '0) begin
      plan_addr = p_base_q;
      plan_left = p_sym_q ? BW'(PS_BEATS) : BW'(PF_BEATS);
    end
    to_4k  = (13'h1000 - {1'b0, plan_addr[11:0]}) >> SIZE;
    plan_n = 9'(MAX_BURST);
    if (int'(plan_left) < int'(plan_n)) plan_n = 9'(plan_left);
    if (int'(to_4k) < int'(plan_n))     plan_n = to_4k[8:0];
  end

  // pack the next LANES words from the cursor; the triangle walk restarts each row at c=r
  always_comb begin
    beat_data = '0;
    beat_strb = '0;
    br        = r_q;
    bc        = c_q;
    bleft     = wleft_q;
    for (int l = 0; l < LANES; l++) begin
      if (bleft != '0) begin
        if (region_q == REG_X)
          beat_data[l*ELEM_W +: ELEM_W] = x_q[int'(bc)*ELEM_W +: ELEM_W];
        else
          beat_data[l*ELEM_W +: ELEM_W] = p_q[(int'(br)*N + int'(bc))*ELEM_W +: ELEM_W];
        beat_strb[l*LANE_B +: LANE_B] = '1;
        bleft = bleft - WW'(1);
        if (region_q == REG_P && bc == CW'(N - 1)) begin
          br = br + CW'(1);
          bc = p_sym_q ? br : '0;
        end else begin
          bc = bc + CW'(1);
        end
      end
    end
  end

  // snapshot of the vectors; pure data path, no reset needed
  always_ff @(posedge clk) begin
    if (start_acc) begin
      x_q <= x_in;
      p_q <= p_in;
    end
  end

  // burst sequencing, beat loading and error capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_base_q   <= '0;
      p_sym_q    <= 1'b0;
      region_q   <= REG_X;
      cur_addr_q <= '0;
      left_q     <= '0;
      r_q        <= '0;
      c_q        <= '0;
      wleft_q    <= '0;
      awaddr_q   <= '0;
      awlen_q    <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wlast_q    <= 1'b0;
      beat_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_resp_q <= 2'b00;
    end else begin
      done_q <= fin;

      if (start_acc) begin
        p_base_q   <= p_base & ~ALIGN_MASK;
        p_sym_q    <= p_sym_mode;
        region_q   <= REG_X;
        r_q        <= '0;
        c_q        <= '0;
        wleft_q    <= WW'(X_WORDS);
        err_q      <= 1'b0;
        err_resp_q <= 2'b00;
      end

      // a new burst is planned on start and after every response that is not the last
      if (start_acc || (b_hs && !fin)) begin
        awaddr_q   <= plan_addr;
        awlen_q    <= 8'(plan_n - 9'd1);
        cur_addr_q <= plan_addr + (AXI_AW'(plan_n) << SIZE);
        left_q     <= plan_left - BW'(plan_n);
      end

      if (b_hs && !fin && left_q == '0) begin
        region_q <= REG_P;
        r_q      <= '0;
        c_q      <= '0;
        wleft_q  <= p_sym_q ? WW'(PS_WORDS) : WW'(PF_WORDS);
      end

      if (aw_hs || (w_hs && !wlast_q)) begin
        wdata_q <= beat_data;
        wstrb_q <= beat_strb;
        r_q     <= br;
        c_q     <= bc;
        wleft_q <= bleft;
        if (aw_hs) begin
          beat_q  <= '0;
          wlast_q <= (awlen_q == 8'd0);
        end else begin
          beat_q  <= beat_q + 8'd1;
          wlast_q <= ((beat_q + 8'd1) == awlen_q);
        end
      end else if (w_hs) begin
        wdata_q <= '0;
        wstrb_q <= '0;
        wlast_q <= 1'b0;
      end

      if (b_hs && axi_bresp != 2'b00) begin
        err_q <= 1'b1;
        if (!err_q) err_resp_q <= axi_bresp;
      end
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign err         = err_q;
  assign err_resp    = err_resp_q;
  assign axi_awaddr  = awaddr_q;
  assign axi_awlen   = awlen_q;
  assign axi_awsize  = 3'(SIZE);
  assign axi_awburst = 2'b01;
  assign axi_awvalid = (state_q == S_AW);
  assign axi_wdata   = wdata_q;
  assign axi_wstrb   = wstrb_q;
  assign axi_wlast   = wlast_q;
  assign axi_wvalid  = (state_q == S_W);
  assign axi_bready  = (state_q == S_B);

endmodule

// File: tb/tb_kf_axi_result_burst_writer.sv
// Directed bench for kf_axi_result_burst_writer with an AXI slave model,
// handshake monitor and an independent packing model for the expected beats.
module tb_kf_axi_result_burst_writer;

  localparam int N = 12;

  logic              clk, rst_n, start, p_sym_mode;
  logic [31:0]       x_base, p_base;
  logic [N*64-1:0]   x_in;
  logic [N*N*64-1:0] p_in;
  logic              busy, done, err;
  logic [1:0]        err_resp;
  logic [31:0]       axi_awaddr;
  logic [7:0]        axi_awlen;
  logic [2:0]        axi_awsize;
  logic [1:0]        axi_awburst;
  logic              axi_awvalid, axi_awready;
  logic [511:0]      axi_wdata;
  logic [63:0]       axi_wstrb;
  logic              axi_wlast, axi_wvalid, axi_wready;
  logic [1:0]        axi_bresp;
  logic              axi_bvalid, axi_bready;

  kf_axi_result_burst_writer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .p_sym_mode(p_sym_mode),
    .x_base(x_base), .p_base(p_base), .x_in(x_in), .p_in(p_in),
    .busy(busy), .done(done), .err(err), .err_resp(err_resp),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
    .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
  );

  int n_run = 0;
  int n_fail = 0;

  logic [31:0]  awa_q[$];
  logic [7:0]   awl_q[$];
  logic [511:0] wd_q[$];
  logic [63:0]  ws_q[$];
  int           done_cnt = 0;
  logic         stall_en = 1'b0;
  logic [1:0]   resp_tab [8];

  task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] xval(input int i);
    return 64'h5A00_0000_0000_0000 + 64'(i) * 64'h0000_0101_0000_0003;
  endfunction

  function automatic logic [63:0] pval(input int r, input int c);
    return 64'hC300_0000_0000_0000 | (64'(r) << 24) | (64'(c) << 4) | 64'h9;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // slave model: ready stalls and per-burst write responses
  initial begin
    axi_awready = 1'b1;
    axi_wready  = 1'b1;
    axi_bvalid  = 1'b1;
    axi_bresp   = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      axi_awready = stall_en ? ($urandom_range(0, 9) >= 3) : 1'b1;
      axi_wready  = stall_en ? ($urandom_range(0, 9) >= 3) : 1'b1;
      axi_bresp   = (awa_q.size() > 0 && awa_q.size() <= 8) ? resp_tab[awa_q.size()-1] : 2'b00;
    end
  end

  // monitor: handshakes, stall stability, wlast placement, done pulses
  initial begin
    logic         aw_stall, w_stall;
    logic [40:0]  aw_prev;
    logic [577:0] w_prev;
    logic [7:0]   cur_len;
    int           beat_idx;
    aw_stall = 1'b0; w_stall = 1'b0; aw_prev = '0; w_prev = '0;
    cur_len = '0; beat_idx = 0;
    forever begin
      @(negedge clk);
      if (aw_stall) chk("aw_hold", {axi_awvalid, axi_awaddr, axi_awlen}, aw_prev);
      if (w_stall)  chk("w_hold", {axi_wvalid, axi_wdata, axi_wstrb, axi_wlast}, w_prev);
      aw_stall = axi_awvalid && !axi_awready;
      aw_prev  = {axi_awvalid, axi_awaddr, axi_awlen};
      w_stall  = axi_wvalid && !axi_wready;
      w_prev   = {axi_wvalid, axi_wdata, axi_wstrb, axi_wlast};
      if (axi_awvalid && axi_awready) begin
        awa_q.push_back(axi_awaddr);
        awl_q.push_back(axi_awlen);
        cur_len  = axi_awlen;
        beat_idx = 0;
      end
      if (axi_wvalid && axi_wready) begin
        wd_q.push_back(axi_wdata);
        ws_q.push_back(axi_wstrb);
        chk("wlast_pos", axi_wlast, (beat_idx == int'(cur_len)));
        beat_idx++;
      end
      if (done) done_cnt++;
    end
  end

  task automatic clear_cap();
    awa_q.delete(); awl_q.delete(); wd_q.delete(); ws_q.delete();
    done_cnt = 0;
  endtask

  task automatic start_xfer(input logic [31:0] xb, input logic [31:0] pb, input logic sym);
    @(negedge clk);
    for (int i = 0; i < N; i++) x_in[i*64 +: 64] = xval(i);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) p_in[(r*N+c)*64 +: 64] = pval(r, c);
    x_base = xb; p_base = pb; p_sym_mode = sym; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 4000) begin
      @(posedge clk);
      n++;
    end
    chk({tag, "_in_time"}, (n < 4000), 1'b1);
    repeat (4) @(negedge clk);
    #1;
    chk({tag, "_done_once"}, done_cnt, 1);
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  task automatic check_aw(input string tag, input int k, input logic [31:0] a, input logic [7:0] l);
    chk({tag, "_present"}, (awa_q.size() > k), 1'b1);
    if (awa_q.size() > k) begin
      chk({tag, "_addr"}, awa_q[k], a);
      chk({tag, "_len"}, awl_q[k], l);
    end
  endtask

  task automatic check_data(input string tag, input logic sym);
    logic [63:0]  words[$];
    logic [511:0] eb[$];
    logic [63:0]  es[$];
    logic [511:0] d;
    logic [63:0]  s;
    for (int rg = 0; rg < 2; rg++) begin
      words.delete();
      if (rg == 0) begin
        for (int i = 0; i < N; i++) words.push_back(xval(i));
      end else begin
        for (int r = 0; r < N; r++)
          for (int c = (sym ? r : 0); c < N; c++) words.push_back(pval(r, c));
      end
      for (int b = 0; b * 8 < words.size(); b++) begin
        d = '0; s = '0;
        for (int l = 0; l < 8; l++)
          if (b * 8 + l < words.size()) begin
            d[l*64 +: 64] = words[b*8+l];
            s[l*8 +: 8]   = 8'hFF;
          end
        eb.push_back(d);
        es.push_back(s);
      end
    end
    chk({tag, "_nbeats"}, wd_q.size(), eb.size());
    for (int b = 0; b < eb.size() && b < wd_q.size(); b++) begin
      chk($sformatf("%s_data%0d", tag, b), wd_q[b], eb[b]);
      chk($sformatf("%s_strb%0d", tag, b), ws_q[b], es[b]);
    end
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; p_sym_mode = 1'b0;
    x_base = '0; p_base = '0; x_in = '0; p_in = '0;
    for (int i = 0; i < 8; i++) resp_tab[i] = 2'b00;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {axi_awvalid, axi_wvalid, axi_bready, busy, done, err, err_resp, axi_wlast}, '0);
    chk("rst_aw", {axi_awaddr, axi_awlen, axi_wstrb}, '0);
    chk("rst_wdata", axi_wdata, '0);
    chk("rst_const", {axi_awsize, axi_awburst}, {3'd6, 2'b01});
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // T1: full mode, no stalls; a second start while busy must be ignored
    clear_cap();
    start_xfer(32'h0050_0000, 32'h0060_0000, 1'b0);
    chk("t1_busy", {busy, axi_awvalid}, 2'b11);
    repeat (4) @(negedge clk);
    x_base = 32'h0070_0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t1");
    chk("t1_awcnt", awa_q.size(), 3);
    check_aw("t1_x", 0, 32'h0050_0000, 8'd1);
    check_aw("t1_p0", 1, 32'h0060_0000, 8'd15);
    check_aw("t1_p1", 2, 32'h0060_0400, 8'd1);
    check_data("t1", 1'b0);
    if (wd_q.size() >= 2) begin
      chk("t1_xb1_strb", ws_q[1], 64'h0000_0000_FFFF_FFFF);
      chk("t1_xb1_upper", wd_q[1][511:256], '0);
    end

    // T2: triangle mode; unaligned x_base low bits are dropped
    clear_cap();
    start_xfer(32'h0050_0013, 32'h0060_0000, 1'b1);
    wait_done("t2");
    chk("t2_awcnt", awa_q.size(), 2);
    check_aw("t2_x", 0, 32'h0050_0000, 8'd1);
    check_aw("t2_p", 1, 32'h0060_0000, 8'd9);
    check_data("t2", 1'b1);
    if (wd_q.size() == 12) begin
      chk("t2_b0_l1", wd_q[2][127:64], pval(0, 1));
      chk("t2_b1_l4", wd_q[3][319:256], pval(1, 1));
      chk("t2_b9_strb", ws_q[11], 64'h0000_FFFF_FFFF_FFFF);
      chk("t2_b9_l67", wd_q[11][511:384], '0);
    end

    // T3: P starts 2 beats below a 4 KB boundary
    clear_cap();
    start_xfer(32'h0050_0000, 32'h0060_0F80, 1'b0);
    wait_done("t3");
    chk("t3_awcnt", awa_q.size(), 3);
    check_aw("t3_p0", 1, 32'h0060_0F80, 8'd1);
    check_aw("t3_p1", 2, 32'h0060_1000, 8'd15);
    check_data("t3", 1'b0);

    // T4: random stalls; inputs scrambled after start to prove the snapshot
    clear_cap();
    stall_en = 1'b1;
    start_xfer(32'h0050_0000, 32'h0060_0000, 1'b0);
    x_in = '1; p_in = '1;
    wait_done("t4");
    stall_en = 1'b0;
    chk("t4_awcnt", awa_q.size(), 3);
    check_aw("t4_p1", 2, 32'h0060_0400, 8'd1);
    check_data("t4", 1'b0);

    // T5: SLVERR on X, DECERR on second P burst; first error code kept
    clear_cap();
    resp_tab[0] = 2'b10;
    resp_tab[2] = 2'b11;
    start_xfer(32'h0050_0000, 32'h0060_0000, 1'b0);
    wait_done("t5");
    chk("t5_awcnt", awa_q.size(), 3);
    chk("t5_err", {err, err_resp}, {1'b1, 2'b10});
    resp_tab[0] = 2'b00;
    resp_tab[2] = 2'b00;
    clear_cap();
    start_xfer(32'h0050_0000, 32'h0060_0000, 1'b0);
    chk("t5_err_clr", {err, err_resp}, 3'b000);
    wait_done("t5b");
    chk("t5b_err", err, 1'b0);

    // T6: reset during P beat 5, then a clean restart
    clear_cap();
    start_xfer(32'h0050_0000, 32'h0060_0000, 1'b0);
    begin
      int n;
      n = 0;
      while (wd_q.size() < 7 && n < 2000) begin
        @(posedge clk);
        n++;
      end
      chk("t6_reach_beat5", (n < 2000), 1'b1);
    end
    @(negedge clk);
    #1;
    chk("t6_pre_wvalid", axi_wvalid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_drop", {axi_awvalid, axi_wvalid, axi_bready, busy}, 4'b0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("t6_no_done", done_cnt, 0);
    clear_cap();
    start_xfer(32'h0050_0000, 32'h0060_0000, 1'b0);
    wait_done("t6");
    check_aw("t6_x", 0, 32'h0050_0000, 8'd1);
    chk("t6_awcnt", awa_q.size(), 3);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
